// File: rtl/mips_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : mips_bus_arb
// Purpose  : Merges the MIPS I core's instruction-fetch and data buses onto
//            one shared memory port with a ready handshake, per-requester
//            completion pulses, a pipeline stall level and a wait timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mips_bus_arb #(
  parameter logic [31:0] START   = 32'b0,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  // instruction-fetch requester
  input  logic        cre,
  input  logic [31:0] PC,
  output logic [31:0] op,
  output logic        cvalid,
  // data requester
  input  logic        re,
  input  logic        we,
  input  logic [31:0] DA,
  input  logic [31:0] DO,
  output logic [31:0] DI,
  output logic        dvalid,
  // status
  output logic        err,
  output logic        stall,
  // shared memory port
  output logic [31:0] MA,
  output logic        MR,
  output logic        MW,
  output logic [31:0] MO,
  input  logic [31:0] MI,
  input  logic        MRDY
);

  // Wait counter is a byte unless the timeout needs more range.
  localparam int unsigned CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  // Counter value in the last wait cycle tolerated before an abort.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CODE = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t             state_q;
  logic               last_data_q;   // 1: data was granted most recently
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        ma_q;
  logic               mr_q;
  logic               mw_q;
  logic [31:0]        mo_q;
  logic [31:0]        op_q;
  logic [31:0]        di_q;
  logic               cvalid_q;
  logic               dvalid_q;
  logic               err_q;

  logic pend_code;
  logic pend_data;
  logic grant_code;
  logic grant_data;
  logic time_out;

  // A requester whose valid pulse is high this cycle is already served, so it
  // is masked to avoid a duplicate grant of the same request.
  assign pend_code  = cre & ~cvalid_q;
  assign pend_data  = (re | we) & ~dvalid_q;
  // Under contention the requester not granted last wins.
  assign grant_data = pend_data & (~pend_code | ~last_data_q);
  assign grant_code = pend_code & ~grant_data;
  // Abort when the last tolerated wait cycle passes without ready.
  assign time_out   = (TIMEOUT != 0) && (cnt_q == TO_LAST) && !MRDY;

  // Arbiter FSM: grant, drive the memory port, complete or abort the access.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_data_q <= 1'b0;
      cnt_q       <= '0;
      ma_q        <= START;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
      mo_q        <= 32'b0;
      op_q        <= 32'b0;
      di_q        <= 32'b0;
      cvalid_q    <= 1'b0;
      dvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cvalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (grant_data) begin
            state_q     <= ST_DATA;
            last_data_q <= 1'b1;
            ma_q        <= DA;
            if (we) begin
              mw_q <= 1'b1;
              mo_q <= DO;
            end else begin
              mr_q <= 1'b1;
            end
          end else if (grant_code) begin
            state_q     <= ST_CODE;
            last_data_q <= 1'b0;
            ma_q        <= PC;
            mr_q        <= 1'b1;
          end
        end
        ST_CODE, ST_DATA: begin
          if (MRDY || time_out) begin
            // An aborted access returns 0, which the core executes as a NOP.
            state_q <= ST_IDLE;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            err_q   <= ~MRDY;
            if (state_q == ST_CODE) begin
              op_q     <= MRDY ? MI : 32'b0;
              cvalid_q <= 1'b1;
            end else begin
              dvalid_q <= 1'b1;
              if (mr_q) begin
                di_q <= MRDY ? MI : 32'b0;
              end
            end
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          mr_q    <= 1'b0;
          mw_q    <= 1'b0;
        end
      endcase
    end
  end

  assign op     = op_q;
  assign DI     = di_q;
  assign cvalid = cvalid_q;
  assign dvalid = dvalid_q;
  assign err    = err_q;
  assign MA     = ma_q;
  assign MR     = mr_q;
  assign MW     = mw_q;
  assign MO     = mo_q;
  assign stall  = (cre & ~cvalid_q) | ((re | we) & ~dvalid_q);

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_bus_arb
// Purpose  : Self-checking bench for mips_bus_arb: directed scenarios followed
//            by randomized fetch/data traffic against a memory model, with a
//            queue-based scoreboard checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_bus_arb;

  localparam logic [31:0] START_V = 32'hBFC0_0000;
  localparam int          TO_V    = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cre   = 1'b0;
  logic        re    = 1'b0;
  logic        we    = 1'b0;
  logic        MRDY  = 1'b0;
  logic [31:0] PC    = 32'b0;
  logic [31:0] DA    = 32'b0;
  logic [31:0] DO    = 32'b0;
  logic [31:0] MI    = 32'b0;
  logic [31:0] op, DI, MA, MO;
  logic        cvalid, dvalid, err, stall, MR, MW;

  mips_bus_arb #(.START(START_V), .TIMEOUT(TO_V)) dut (
    .clock(clock), .reset(reset),
    .cre(cre), .PC(PC), .op(op), .cvalid(cvalid),
    .re(re), .we(we), .DA(DA), .DO(DO), .DI(DI), .dvalid(dvalid),
    .err(err), .stall(stall),
    .MA(MA), .MR(MR), .MW(MW), .MO(MO), .MI(MI), .MRDY(MRDY)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t cq[$];
  exp_t dq[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic dir_mode = 1'b1;   // directed: wait count from dir_wait
  int   dir_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents and wait profile as functions of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h100) return 32'h2401_0005;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] memw(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  function automatic int waits(input logic [31:0] a);
    return int'((a >> 2) % 7);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  // Memory: asserts MRDY after the chosen number of wait cycles of a strobe.
  initial begin : mem_model
    int   wcnt;
    int   wt;
    logic prev;
    wcnt = 0;
    prev = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (MR | MW) begin
        if (!prev) wcnt = 0;
        else       wcnt++;
        prev = 1'b1;
        wt   = dir_mode ? dir_wait : waits(MA);
        MRDY = (wcnt == wt);
        MI   = MRDY ? memf(MA) : $urandom;
      end else begin
        prev = 1'b0;
        MRDY = 1'b0;
        MI   = $urandom;
      end
    end
  end

  logic [31:0] di_model    = 32'b0;
  int          acc_cnt     = 0;
  int          val_cnt     = 0;
  logic        strobe_prev = 1'b0;

  // Monitor: pops the scoreboard on each completion pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        di_model    = 32'b0;
        acc_cnt     = val_cnt;
        strobe_prev = 1'b0;
      end else begin
        if ((MR | MW) && !strobe_prev) acc_cnt++;
        strobe_prev = MR | MW;
        check("strobe_exclusive", 32'(MR & MW), 32'h0);
        check("stall", 32'(stall), 32'((cre & ~cvalid) | ((re | we) & ~dvalid)));
        if (!dir_mode && MW && MRDY) check("MO_write_data", MO, memw(MA));
        if (cvalid) begin
          val_cnt++;
          check("cvalid_expected", 32'(cq.size() != 0), 32'h1);
          if (cq.size() != 0) begin
            e = cq.pop_front();
            check("op", op, e.data);
            check("code_err", 32'(err), 32'(e.err));
          end
        end
        if (dvalid) begin
          val_cnt++;
          check("dvalid_expected", 32'(dq.size() != 0), 32'h1);
          if (dq.size() != 0) begin
            e = dq.pop_front();
            if (!e.wr) di_model = e.data;
            check("DI", DI, di_model);
            check("data_err", 32'(err), 32'(e.err));
          end
        end
      end
    end
  end

  task automatic wait_valid(input bit code, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (code ? cvalid : dvalid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_wait: no valid pulse within %0d cycles", code ? "code" : "data", budget);
    end
  endtask

  task automatic code_drv(input int n);
    logic [31:0] a;
    bit          ok;
    bit          to;
    for (int i = 0; i < n; i++) begin
      if (!cre) repeat ($urandom_range(0, 3)) step();
      a   = $urandom & 32'hFFFF_FFFC;
      to  = (waits(a) >= TO_V);
      PC  = a;
      cre = 1'b1;
      cq.push_back('{wr: 1'b0, data: to ? 32'h0 : memf(a), err: to});
      wait_valid(1'b1, 100, ok);
      step();
      if (!ok || $urandom_range(0, 1) == 0) cre = 1'b0;
    end
    cre = 1'b0;
  endtask

  task automatic data_drv(input int n);
    logic [31:0] a;
    int          k;
    bit          ok;
    bit          to;
    for (int i = 0; i < n; i++) begin
      if (!(re | we)) repeat ($urandom_range(0, 3)) step();
      a  = $urandom & 32'hFFFF_FFFC;
      k  = $urandom_range(0, 2);     // 0 read, 1 write, 2 read+write
      to = (waits(a) >= TO_V);
      DA = a;
      DO = memw(a);
      re = (k != 1);
      we = (k != 0);
      dq.push_back('{wr: (k != 0), data: to ? 32'h0 : memf(a), err: to});
      wait_valid(1'b0, 100, ok);
      step();
      if (!ok || $urandom_range(0, 1) == 0) begin
        re = 1'b0;
        we = 1'b0;
      end
    end
    re = 1'b0;
    we = 1'b0;
  endtask

  initial begin : main
    bit ok;
    repeat (3) step();
    at_neg();
    check("rst_MA", MA, START_V);
    check("rst_MR", 32'(MR), 32'h0);
    check("rst_MW", 32'(MW), 32'h0);
    check("rst_MO", MO, 32'h0);
    check("rst_op", op, 32'h0);
    check("rst_DI", DI, 32'h0);
    check("rst_cvalid", 32'(cvalid), 32'h0);
    check("rst_dvalid", 32'(dvalid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    step();
    reset = 1'b0;

    // Single zero-wait fetch.
    dir_wait = 0;
    step();
    cre = 1'b1; PC = 32'h100;
    cq.push_back('{wr: 1'b0, data: 32'h2401_0005, err: 1'b0});
    at_neg(); check("t1_stall_N", 32'(stall), 32'h1);
    step(); at_neg();
    check("t1_MR", 32'(MR), 32'h1); check("t1_MA", MA, 32'h100); check("t1_MW", 32'(MW), 32'h0);
    step(); at_neg();
    check("t1_cvalid", 32'(cvalid), 32'h1); check("t1_MR_off", 32'(MR), 32'h0);
    step(); cre = 1'b0;

    // Contention with last grant = code: data first, then code.
    step();
    cre = 1'b1; PC = 32'h200; re = 1'b1; DA = 32'h3000;
    dq.push_back('{wr: 1'b0, data: memf(32'h3000), err: 1'b0});
    cq.push_back('{wr: 1'b0, data: memf(32'h200), err: 1'b0});
    step(); at_neg();
    check("t2_MA_data", MA, 32'h3000); check("t2_MR", 32'(MR), 32'h1);
    step(); at_neg(); check("t2_dvalid", 32'(dvalid), 32'h1);
    step(); re = 1'b0;
    at_neg(); check("t2_MA_code", MA, 32'h200); check("t2_MR_code", 32'(MR), 32'h1);
    step(); at_neg(); check("t2_cvalid", 32'(cvalid), 32'h1);
    step(); cre = 1'b0;

    // Write with three wait states.
    dir_wait = 3;
    step();
    we = 1'b1; DA = 32'h2000; DO = 32'hDEAD_BEEF;
    dq.push_back('{wr: 1'b1, data: 32'h0, err: 1'b0});
    for (int k = 0; k < 4; k++) begin
      step(); at_neg();
      check("t3_MW", 32'(MW), 32'h1); check("t3_MO", MO, 32'hDEAD_BEEF);
      check("t3_MA", MA, 32'h2000); check("t3_no_dvalid", 32'(dvalid), 32'h0);
    end
    step(); at_neg();
    check("t3_dvalid", 32'(dvalid), 32'h1); check("t3_MW_off", 32'(MW), 32'h0);
    step(); we = 1'b0;

    // Contention with last grant = data: code wins.
    dir_wait = 0;
    step();
    cre = 1'b1; PC = 32'h240; re = 1'b1; DA = 32'h3100;
    cq.push_back('{wr: 1'b0, data: memf(32'h240), err: 1'b0});
    dq.push_back('{wr: 1'b0, data: memf(32'h3100), err: 1'b0});
    step(); at_neg(); check("t2b_MA_code", MA, 32'h240); check("t2b_MR", 32'(MR), 32'h1);
    step(); at_neg(); check("t2b_cvalid", 32'(cvalid), 32'h1);
    step(); cre = 1'b0;
    at_neg(); check("t2b_MA_data", MA, 32'h3100);
    step(); at_neg(); check("t2b_dvalid", 32'(dvalid), 32'h1);
    step(); re = 1'b0;

    // Fetch timeout with memory never ready.
    dir_wait = 1000;
    step();
    cre = 1'b1; PC = 32'h400;
    cq.push_back('{wr: 1'b0, data: 32'h0, err: 1'b1});
    for (int k = 0; k < TO_V; k++) begin
      step(); at_neg();
      check("t4_MR_held", 32'(MR), 32'h1); check("t4_no_cvalid", 32'(cvalid), 32'h0);
    end
    step(); at_neg();
    check("t4_cvalid", 32'(cvalid), 32'h1); check("t4_MR_off", 32'(MR), 32'h0);
    step(); cre = 1'b0;

    // Reset during the second wait cycle of a data read.
    step();
    re = 1'b1; DA = 32'h5000;
    step(); at_neg(); check("t5_MR_c1", 32'(MR), 32'h1);
    step(); reset = 1'b1; re = 1'b0;
    step(); reset = 1'b0;
    at_neg();
    check("t5_MR", 32'(MR), 32'h0); check("t5_MA", MA, START_V);
    check("t5_DI", DI, 32'h0); check("t5_dvalid", 32'(dvalid), 32'h0);
    dir_wait = 1;
    step();
    re = 1'b1; DA = 32'h5000;
    dq.push_back('{wr: 1'b0, data: memf(32'h5000), err: 1'b0});
    wait_valid(1'b0, 20, ok);
    step(); re = 1'b0;

    // Request held through the valid pulse, then a new PC.
    dir_wait = 0;
    step();
    cre = 1'b1; PC = 32'h600;
    cq.push_back('{wr: 1'b0, data: memf(32'h600), err: 1'b0});
    step(); step(); at_neg(); check("t6_cvalid1", 32'(cvalid), 32'h1);
    step();
    PC = 32'h700;
    cq.push_back('{wr: 1'b0, data: memf(32'h700), err: 1'b0});
    at_neg(); check("t6_no_regrant", 32'(MR), 32'h0);
    step(); at_neg(); check("t6_MR2", 32'(MR), 32'h1); check("t6_MA2", MA, 32'h700);
    step(); at_neg(); check("t6_cvalid2", 32'(cvalid), 32'h1);
    step(); cre = 1'b0;

    // Randomized concurrent traffic.
    step();
    dir_mode = 1'b0;
    fork
      code_drv(40);
      data_drv(40);
    join
    repeat (5) step();
    at_neg();
    check("accesses_vs_valids", 32'(acc_cnt), 32'(val_cnt));
    check("code_queue_empty", 32'(cq.size()), 32'h0);
    check("data_queue_empty", 32'(dq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
